// File: rtl/onewire_sensor_reader_pkg.sv
// Shared types and sensor presets for the single-wire DHT-family reader.
// Holds the controller state encoding and a constant helper for sizing counters.
package onewire_sensor_reader_pkg;

   typedef enum logic [3:0] {
      IDLE,
      START_LOW,
      RELEASE,
      RESP_LOW,
      RESP_HIGH,
      BIT_LOW,
      BIT_HIGH,
      FINISH,
      ERROR
   } state_t;

   localparam int DHT11_START_LOW_US = 18000;
   localparam int DHT22_START_LOW_US = 1000;
   localparam int DHT11_HOLDOFF_US   = 1000000;
   localparam int DHT22_HOLDOFF_US   = 2000000;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/onewire_sensor_reader_us_tick_gen.sv
// Microsecond prescaler: one-cycle tick every CLKS_PER_US clocks.
// A restart realigns the tick grid so phase timing starts from a clean boundary.
module us_tick_gen #(
   parameter int CLKS_PER_US = 50
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int CW = $clog2(CLKS_PER_US);

   logic [CW-1:0] cnt_reg;

   assign tick = (cnt_reg == CW'(CLKS_PER_US - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg <= '0;
      end else if (restart || tick) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + CW'(1);
      end
   end

endmodule

// File: rtl/onewire_sensor_reader.sv
// Single-wire DHT-family reader: start pulse, response handshake, pulse-width
// decoded frame capture, checksum check and post-transaction hold-off.
module onewire_sensor_reader
   import onewire_sensor_reader_pkg::*;
#(
   parameter int CLKS_PER_US   = 50,
   parameter int START_LOW_US  = DHT11_START_LOW_US,
   parameter int RELEASE_US    = 30,
   parameter int BIT_THRESH_US = 48,
   parameter int TIMEOUT_US    = 200,
   parameter int HOLDOFF_US    = DHT11_HOLDOFF_US,
   parameter int NBITS         = 40
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             dq_in,
   output logic             dq_oe,
   output logic             busy,
   output logic             done,
   output logic [NBITS-1:0] data,
   output logic             crc_ok,
   output logic             timeout_err
);

   // The release phase timer runs through its fixed wait plus the timeout window.
   localparam int TMAX   = max3(START_LOW_US, HOLDOFF_US, RELEASE_US + TIMEOUT_US) + 1;
   localparam int TW     = $clog2(TMAX + 1);
   localparam int BW     = $clog2(NBITS + 1);
   localparam int NBYTES = NBITS / 8;

   state_t           state_reg, state_next;
   logic [2:0]       dq_sync_reg;
   logic             dq_s, dq_rise, dq_fall;
   logic             tick, restart, phase_timeout;
   logic [TW-1:0]    timer_reg, holdoff_reg;
   logic [BW-1:0]    bit_cnt_reg;
   logic [NBITS-1:0] shift_reg, data_reg;
   logic             crc_ok_reg, timeout_err_reg;
   logic [7:0]       byte_sum;

   us_tick_gen #(.CLKS_PER_US(CLKS_PER_US)) u_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (restart),
      .tick    (tick)
   );

   assign dq_s          = dq_sync_reg[1];
   assign dq_rise       = dq_sync_reg[1] & ~dq_sync_reg[2];
   assign dq_fall       = ~dq_sync_reg[1] & dq_sync_reg[2];
   assign restart       = (state_next != state_reg);
   assign phase_timeout = tick && (timer_reg >= TW'(TIMEOUT_US));

   assign dq_oe       = (state_reg == START_LOW);
   assign busy        = !(state_reg inside {IDLE, FINISH, ERROR});
   assign done        = (state_reg == FINISH) || (state_reg == ERROR);
   assign data        = data_reg;
   assign crc_ok      = crc_ok_reg;
   assign timeout_err = timeout_err_reg;

   always_comb begin
      byte_sum = '0;
      for (int i = 1; i < NBYTES; i++) begin
         byte_sum = byte_sum + shift_reg[8*i +: 8];
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:      if (start && holdoff_reg == '0) state_next = START_LOW;
         START_LOW: if (tick && timer_reg == TW'(START_LOW_US - 1)) state_next = RELEASE;
         RELEASE: begin
            if (timer_reg >= TW'(RELEASE_US) && !dq_s) state_next = RESP_LOW;
            else if (tick && timer_reg >= TW'(RELEASE_US + TIMEOUT_US)) state_next = ERROR;
         end
         RESP_LOW: begin
            if (dq_rise) state_next = RESP_HIGH;
            else if (phase_timeout) state_next = ERROR;
         end
         RESP_HIGH: begin
            if (dq_fall) state_next = BIT_LOW;
            else if (phase_timeout) state_next = ERROR;
         end
         BIT_LOW: begin
            if (dq_rise) state_next = BIT_HIGH;
            else if (phase_timeout) state_next = ERROR;
         end
         BIT_HIGH: begin
            if (dq_fall) state_next = (bit_cnt_reg == BW'(NBITS - 1)) ? FINISH : BIT_LOW;
            else if (phase_timeout) state_next = ERROR;
         end
         FINISH:    state_next = IDLE;
         ERROR:     state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg       <= IDLE;
         dq_sync_reg     <= 3'b111;
         timer_reg       <= '0;
         holdoff_reg     <= '0;
         bit_cnt_reg     <= '0;
         shift_reg       <= '0;
         data_reg        <= '0;
         crc_ok_reg      <= 1'b0;
         timeout_err_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         dq_sync_reg <= {dq_sync_reg[1:0], dq_in};

         // Idle never advances the phase timer, so it cannot wrap while parked.
         if (restart) timer_reg <= '0;
         else if (tick && state_reg != IDLE) timer_reg <= timer_reg + TW'(1);

         if (state_reg == FINISH || state_reg == ERROR) begin
            holdoff_reg <= TW'(HOLDOFF_US);
         end else if (state_reg == IDLE && tick && holdoff_reg != '0) begin
            holdoff_reg <= holdoff_reg - TW'(1);
         end

         if (state_reg == IDLE) begin
            bit_cnt_reg <= '0;
         end else if (state_reg == BIT_HIGH && dq_fall) begin
            bit_cnt_reg <= bit_cnt_reg + BW'(1);
            shift_reg   <= {shift_reg[NBITS-2:0], (timer_reg > TW'(BIT_THRESH_US))};
         end

         if (state_reg == FINISH) begin
            data_reg        <= shift_reg;
            crc_ok_reg      <= (byte_sum == shift_reg[7:0]);
            timeout_err_reg <= 1'b0;
         end else if (state_reg == ERROR) begin
            timeout_err_reg <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_onewire_sensor_reader.sv
// Bench for onewire_sensor_reader: open-drain sensor model, table of transactions,
// randomized frames against a checksum model, hold-off and async reset sequences.
module tb_onewire_sensor_reader;

   localparam int CPU         = 4;
   localparam int MODE_FULL   = 0;
   localparam int MODE_SILENT = 1;
   localparam int MODE_STOP   = 2;

   typedef struct {
      logic [39:0] frame;
      int          mode;
      int          nbits;
      logic [39:0] exp_data;
      logic        exp_crc;
      logic        exp_te;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, start, dq_in, dq_oe, busy, done, crc_ok, timeout_err;
   logic        sensor_low;
   logic [39:0] data;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   vec_t        vecs[5];

   onewire_sensor_reader #(
      .CLKS_PER_US   (CPU),
      .START_LOW_US  (20),
      .RELEASE_US    (30),
      .BIT_THRESH_US (48),
      .TIMEOUT_US    (200),
      .HOLDOFF_US    (50),
      .NBITS         (40)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dq_in       (dq_in),
      .dq_oe       (dq_oe),
      .busy        (busy),
      .done        (done),
      .data        (data),
      .crc_ok      (crc_ok),
      .timeout_err (timeout_err)
   );

   assign dq_in = ~(dq_oe | sensor_low);

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s = 0x%0h", name, act);
      end
   endtask

   task automatic chk_rng(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end else begin
         $display("ok   %s = %0d", name, act);
      end
   endtask

   task automatic us(input int n);
      repeat (n * CPU) @(negedge clk);
   endtask

   task automatic wait_done(input string tag, input int lim, output int dcyc);
      int t;
      bit oe_seen;
      t = 0;
      oe_seen = 1'b0;
      while (done !== 1'b1 && t < lim) begin
         @(negedge clk);
         t++;
         if (dq_oe === 1'b1) oe_seen = 1'b1;
      end
      chk({tag, "_done_seen"}, 64'(done), 64'(1));
      chk({tag, "_busy_at_done"}, 64'(busy), 64'(0));
      chk({tag, "_start_ignored_while_busy"}, 64'(oe_seen), 64'(0));
      dcyc = cyc;
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, 64'(done), 64'(0));
   endtask

   task automatic run_txn(input string tag, input logic [39:0] frame, input int mode,
                          input int nb, input bit keep_start, output int dcyc);
      int t, hi, rel_cyc;
      @(negedge clk);
      start = 1'b1;
      t = 0;
      while (dq_oe !== 1'b1 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      chk({tag, "_start_accepted"}, 64'(dq_oe), 64'(1));
      chk({tag, "_busy_in_start"}, 64'(busy), 64'(1));
      if (!keep_start) start = 1'b0;
      hi = 0;
      while (dq_oe === 1'b1 && hi < 1000) begin
         @(negedge clk);
         hi++;
      end
      chk_rng({tag, "_start_low_cycles"}, hi, 76, 84);
      rel_cyc = cyc;
      if (mode == MODE_SILENT) begin
         wait_done(tag, 1200, dcyc);
         chk_rng({tag, "_timeout_delay"}, dcyc - rel_cyc, 916, 936);
      end else begin
         us(35); sensor_low = 1'b1;
         us(80); sensor_low = 1'b0;
         us(80);
         for (int i = 0; i < nb; i++) begin
            sensor_low = 1'b1;
            us(8);
            sensor_low = 1'b0;
            us(frame[39-i] ? 60 : 24);
         end
         sensor_low = 1'b1;
         if (mode == MODE_STOP) begin
            us(8);
            sensor_low = 1'b0;
            wait_done(tag, 1200, dcyc);
         end else begin
            wait_done(tag, 40, dcyc);
            sensor_low = 1'b0;
         end
      end
      chk({tag, "_dq_oe_released"}, 64'(dq_oe), 64'(0));
   endtask

   initial begin
      int dcyc, gap, t;
      logic [7:0]  b[4];
      logic [7:0]  last;
      logic [39:0] frame;
      int          sum;
      logic        exp_crc;

      vecs[0] = '{40'h350018004D, MODE_FULL,   40, 40'h350018004D, 1'b1, 1'b0};
      vecs[1] = '{40'h350018004E, MODE_FULL,   40, 40'h350018004E, 1'b0, 1'b0};
      vecs[2] = '{40'h0000000000, MODE_SILENT,  0, 40'h350018004E, 1'b0, 1'b1};
      vecs[3] = '{40'hA5A5A5A5A5, MODE_STOP,   17, 40'h350018004E, 1'b0, 1'b1};
      vecs[4] = '{40'h11223344AA, MODE_FULL,   40, 40'h11223344AA, 1'b1, 1'b0};

      rst = 1'b0;
      start = 1'b0;
      sensor_low = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_dq_oe", 64'(dq_oe), 64'(0));
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_done", 64'(done), 64'(0));
      chk("reset_data", 64'(data), 64'(0));
      chk("reset_crc_ok", 64'(crc_ok), 64'(0));
      chk("reset_timeout_err", 64'(timeout_err), 64'(0));
      rst = 1'b1;

      for (int i = 0; i < 5; i++) begin
         run_txn($sformatf("vec%0d", i), vecs[i].frame, vecs[i].mode, vecs[i].nbits, 1'b0, dcyc);
         chk($sformatf("vec%0d_data", i), 64'(data), 64'(vecs[i].exp_data));
         chk($sformatf("vec%0d_crc_ok", i), 64'(crc_ok), 64'(vecs[i].exp_crc));
         chk($sformatf("vec%0d_timeout_err", i), 64'(timeout_err), 64'(vecs[i].exp_te));
      end

      // Random frames: checksum expectation is plain byte arithmetic.
      for (int r = 0; r < 2; r++) begin
         sum = 0;
         for (int k = 0; k < 4; k++) begin
            b[k] = 8'($urandom_range(0, 255));
            sum += int'(b[k]);
         end
         last = 8'(sum % 256);
         if ($urandom_range(0, 1) == 1) last = last ^ 8'($urandom_range(1, 255));
         frame = {b[3], b[2], b[1], b[0], last};
         exp_crc = ((sum % 256) == int'(last));
         run_txn($sformatf("rnd%0d", r), frame, MODE_FULL, 40, 1'b0, dcyc);
         chk($sformatf("rnd%0d_data", r), 64'(data), 64'(frame));
         chk($sformatf("rnd%0d_crc_ok", r), 64'(crc_ok), 64'(exp_crc));
         chk($sformatf("rnd%0d_timeout_err", r), 64'(timeout_err), 64'(0));
      end

      // start held continuously: next start must wait out the 50 us hold-off.
      run_txn("hold", 40'h0, MODE_SILENT, 0, 1'b1, dcyc);
      t = 0;
      while (dq_oe !== 1'b1 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      gap = cyc - dcyc;
      chk_rng("holdoff_gap_cycles", gap, 200, 212);

      // Async reset in the middle of the start pulse.
      repeat (20) @(negedge clk);
      start = 1'b0;
      chk("pre_reset_dq_oe", 64'(dq_oe), 64'(1));
      #2 rst = 1'b0;
      #1;
      chk("midrst_dq_oe", 64'(dq_oe), 64'(0));
      chk("midrst_busy", 64'(busy), 64'(0));
      chk("midrst_done", 64'(done), 64'(0));
      chk("midrst_data", 64'(data), 64'(0));
      chk("midrst_crc_ok", 64'(crc_ok), 64'(0));
      chk("midrst_timeout_err", 64'(timeout_err), 64'(0));
      @(negedge clk);
      rst = 1'b1;
      start = 1'b1;
      @(negedge clk);
      chk("start_after_reset", 64'(dq_oe), 64'(1));
      start = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
